axis_pkt_rr_arbiter: RTL and testbench
======================================

AXIS_PKT_RR_ARBITER -- requirements
Module: axis_pkt_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, the number of requester ports; it is fixed at 4 and gives a 2-bit port index.
REQ-002 SHALL have parameter DW, default 64, the data width per port; keep width is DW/8.
REQ-003 SHALL have port tx_axis_uclk, input, 1 bit: the single clock; every flop samples its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_axis_tvalid, input, N bits: per-port valid.
REQ-006 SHALL have port rx_axis_tready, output, N bits: per-port ready.
REQ-007 SHALL have port rx_axis_tdata, input, N*DW bits: port i occupies bits [i*DW +: DW].
REQ-008 SHALL have port rx_axis_tkeep, input, N*DW/8 bits: port i occupies bits [i*8 +: 8].
REQ-009 SHALL have port rx_axis_tlast, input, N bits: per-port end of packet.
REQ-010 SHALL have port tx_axis_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have registered output ports tx_axis_tvalid (1 bit), tx_axis_tdata (DW bits), tx_axis_tkeep (DW/8 bits) and tx_axis_tlast (1 bit): the merged stream.
REQ-012 SHALL have port PortEn, input, N bits: per-port arbitration enable.
REQ-013 SHALL have port CntClr, input, 1 bit: synchronous clear of the packet counters.
REQ-014 SHALL have port GntId, output, 2 bits: the currently granted port.
REQ-015 SHALL have port Busy, output, 1 bit: high while a packet is locked.
REQ-016 SHALL have port TxPkg_Cnt, output, N*32 bits: per-port count of forwarded packets.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-018 SHALL, in IDLE, evaluate the request vector Req = rx_axis_tvalid & PortEn.
REQ-019 SHALL, in IDLE with Req nonzero, load GntId with the first set bit of Req searching upward from (LastGnt+1) mod 4 with wrap, and enter BUSY on the next cycle.
REQ-020 SHALL, in IDLE, drive rx_axis_tready to 0 on every port, giving a 1-cycle arbitration bubble between packets.
REQ-021 SHALL, in BUSY, drive rx_axis_tready[GntId] = ~tx_axis_tvalid | tx_axis_tready and drive all other ports to 0.
REQ-022 SHALL treat a beat as accepted when rx_axis_tvalid[GntId] and rx_axis_tready[GntId] are both high in the same cycle.
REQ-023 SHALL load the output register with the granted port's tdata, tkeep and tlast on an accepted beat and set tx_axis_tvalid to 1.
REQ-024 SHALL clear tx_axis_tvalid when tx_axis_tready is high and no beat is accepted in that cycle.
REQ-025 SHALL hold all tx_axis_* outputs stable while tx_axis_tvalid=1 and tx_axis_tready=0.
REQ-026 SHALL present each accepted beat on tx_axis_* exactly 1 cycle after acceptance, and SHALL sustain 1 beat per cycle under continuous ready.
REQ-027 SHALL, on an accepted beat with tlast=1, set LastGnt to GntId and return to IDLE on the next cycle.
REQ-028 SHALL keep a grant locked until tlast: deasserting PortEn[GntId] or rx_axis_tvalid mid-packet neither releases nor truncates the packet.
REQ-029 SHALL never interleave beats of different packets on tx_axis_*.
REQ-030 SHALL assert Busy exactly while in BUSY.
REQ-031 SHALL increment TxPkg_Cnt[GntId] by 1 when tx_axis_tvalid, tx_axis_tready and tx_axis_tlast are all high, wrapping from 0xFFFFFFFF to 0.
REQ-032 SHALL give CntClr priority over a same-cycle increment, so that all counters read 0 on the next cycle.
REQ-033 SHALL pass tkeep through unmodified; a last beat with tkeep=0x00 is forwarded as-is.
REQ-034 SHALL grant nothing while Req=0, whatever the values on rx_axis_tdata.

Reset
REQ-035 SHALL, while Rst=1, immediately force: FSM=IDLE, GntId=0, LastGnt=3 (so port 0 wins first), tx_axis_tvalid=0, tx_axis_tlast=0, tx_axis_tdata=0, tx_axis_tkeep=0, rx_axis_tready=0, Busy=0, and all TxPkg_Cnt=0.
REQ-036 SHALL, on Rst asserted mid-packet, abandon the packet and start from port 0 after release, with no partial beat left on tx_axis_*.

Verification
REQ-037 SHALL be verified by: after reset, ports 0–3 each send one 3-beat packet at once, tx_axis_tready=1 -> output order is port 0,1,2,3; 12 beats; 3 idle bubbles; TxPkg_Cnt = 1,1,1,1.
REQ-038 SHALL be verified by: port 2 sends 5 beats while port 1 requests continuously from beat 2 -> port 2's beats are contiguous, then port 1 is granted; GntId goes 2 -> 1.
REQ-039 SHALL be verified by: tx_axis_tready toggling 1,0,0,1 during a packet -> no beat is lost or duplicated, and tdata is stable during the stall cycles.
REQ-040 SHALL be verified by: PortEn=4'b1011 with all ports valid -> port 2 is never granted and rx_axis_tready[2]=0 throughout.
REQ-041 SHALL be verified by: CntClr in the same cycle as a tlast handshake on port 0 -> TxPkg_Cnt[0]=0 on the next cycle.
REQ-042 SHALL be verified by: Rst pulsed on beat 2 of a 4-beat packet -> tx_axis_tvalid=0 immediately; after release, a port 3 request is served.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter_if.sv
// AXI-Stream bundle for the packet arbiter: N request streams in, one merged stream out.
// A beat moves on any stream in a cycle where its tvalid and tready are both high at the rising clock edge.
interface axis_pkt_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 64
);
  localparam int KW = DW / 8;

  logic [N-1:0]    rx_axis_tvalid;
  logic [N-1:0]    rx_axis_tready;
  logic [N*DW-1:0] rx_axis_tdata;
  logic [N*KW-1:0] rx_axis_tkeep;
  logic [N-1:0]    rx_axis_tlast;

  logic            tx_axis_tvalid;
  logic            tx_axis_tready;
  logic [DW-1:0]   tx_axis_tdata;
  logic [KW-1:0]   tx_axis_tkeep;
  logic            tx_axis_tlast;

  // The arbiter takes the slave view; the surrounding environment takes the master view.
  modport slave (
    input  rx_axis_tvalid, rx_axis_tdata, rx_axis_tkeep, rx_axis_tlast, tx_axis_tready,
    output rx_axis_tready, tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast
  );

  modport master (
    output rx_axis_tvalid, rx_axis_tdata, rx_axis_tkeep, rx_axis_tlast, tx_axis_tready,
    input  rx_axis_tready, tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast
  );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-locked round-robin arbiter merging 4 AXI-Stream ports into one registered output stream,
// with per-port forwarded-packet counters. Busy mirrors the FSM state register directly.
module axis_pkt_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 64
) (
  input  logic                 tx_axis_uclk,
  input  logic                 Rst,
  axis_pkt_rr_arbiter_if.slave bus,
  input  logic [N-1:0]         PortEn,
  input  logic                 CntClr,
  output logic [1:0]           GntId,
  output logic                 Busy,
  output logic [N*32-1:0]      TxPkg_Cnt
);
  localparam int KW = DW / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    pick, idx;
  logic [1:0]    tx_port_q;
  logic [N-1:0]  req;
  logic [N-1:0]  rdy_vec;
  logic          out_free;
  logic          accept;
  logic          pkt_done;
  logic [DW-1:0] sel_data;
  logic [KW-1:0] sel_keep;
  logic          sel_last;

  logic          tx_valid_q;
  logic          tx_last_q;
  logic [DW-1:0] tx_data_q;
  logic [KW-1:0] tx_keep_q;
  logic [31:0]   cnt_q [N];

  assign req      = bus.rx_axis_tvalid & PortEn;
  assign out_free = ~tx_valid_q | bus.tx_axis_tready;
  assign sel_data = bus.rx_axis_tdata[int'(gnt_q)*DW +: DW];
  assign sel_keep = bus.rx_axis_tkeep[int'(gnt_q)*KW +: KW];
  assign sel_last = bus.rx_axis_tlast[gnt_q];
  assign accept   = (state_q == BUSY) & bus.rx_axis_tvalid[gnt_q] & out_free;
  assign pkt_done = tx_valid_q & bus.tx_axis_tready & tx_last_q;

  // Walk downward so the port nearest after last_q wins; k == N lands on last_q itself.
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int k = N; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rdy_vec = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        rdy_vec[gnt_q] = out_free;
        if (accept && sel_last) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge tx_axis_uclk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      gnt_q      <= 2'd0;
      last_q     <= 2'd3;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_port_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      if (accept) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= sel_data;
        tx_keep_q  <= sel_keep;
        tx_last_q  <= sel_last;
        tx_port_q  <= gnt_q;
      end else if (bus.tx_axis_tready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  // Credit the port that owns the beat on the output, which can lag gnt_q by one packet.
  always_ff @(posedge tx_axis_uclk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (CntClr) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (pkt_done) begin
      cnt_q[tx_port_q] <= cnt_q[tx_port_q] + 32'd1;
    end
  end

  always_comb begin
    TxPkg_Cnt = '0;
    for (int i = 0; i < N; i++) TxPkg_Cnt[i*32 +: 32] = cnt_q[i];
  end

  assign bus.rx_axis_tready = rdy_vec;
  assign bus.tx_axis_tvalid = tx_valid_q;
  assign bus.tx_axis_tdata  = tx_data_q;
  assign bus.tx_axis_tkeep  = tx_keep_q;
  assign bus.tx_axis_tlast  = tx_last_q;
  assign GntId              = gnt_q;
  assign Busy               = (state_q == BUSY);
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: per-port packet sources, an output beat log,
// and hand-computed expected beat orders, spans, grants and counter values.
module tb_axis_pkt_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic              clk;
  logic              rst;
  logic              cnt_clr;
  logic [N-1:0]      port_en;
  logic [1:0]        gnt_id;
  logic              busy;
  logic [N*32-1:0]   pkt_cnt;

  axis_pkt_rr_arbiter_if #(.N(N), .DW(DW)) bus ();

  axis_pkt_rr_arbiter #(.N(N), .DW(DW)) dut (
    .tx_axis_uclk (clk),
    .Rst          (rst),
    .bus          (bus),
    .PortEn       (port_en),
    .CntClr       (cnt_clr),
    .GntId        (gnt_id),
    .Busy         (busy),
    .TxPkg_Cnt    (pkt_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  int            pushed    [N] = '{default: 0};
  int            len       [N] = '{default: 1};
  logic [KW-1:0] keep_last [N] = '{default: '1};
  int            done      [N];
  int            beat      [N];
  logic [N-1:0]  hs;

  logic [DW-1:0] out_q [$];
  logic [KW-1:0] keep_q[$];
  int            cyc_q [$];
  int            cyc;
  int            rdy2_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int p, input int b);
    return {8'(p), 40'h0, 16'(b)};
  endfunction

  // ---------------- sources: one packet stream per port ----------------
  initial begin
    hs = '0;
    for (int p = 0; p < N; p++) begin
      done[p] = 0;
      beat[p] = 0;
    end
    bus.rx_axis_tvalid = '0;
    bus.rx_axis_tdata  = '0;
    bus.rx_axis_tkeep  = '0;
    bus.rx_axis_tlast  = '0;
    forever begin
      @(negedge clk);
      hs = bus.rx_axis_tvalid & bus.rx_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (rst) begin
          done[p] = pushed[p];
          beat[p] = 0;
        end else if (hs[p]) begin
          if (beat[p] == len[p] - 1) begin
            beat[p] = 0;
            done[p]++;
          end else begin
            beat[p]++;
          end
        end
        bus.rx_axis_tvalid[p]           = (pushed[p] > done[p]);
        bus.rx_axis_tdata[p*DW +: DW]   = mk(p, beat[p]);
        bus.rx_axis_tlast[p]            = (beat[p] == len[p] - 1);
        bus.rx_axis_tkeep[p*KW +: KW]   = (beat[p] == len[p] - 1) ? keep_last[p] : '1;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    cyc      = 0;
    rdy2_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rx_axis_tready[2]) rdy2_cnt++;
      if (bus.tx_axis_tvalid && bus.tx_axis_tready) begin
        out_q.push_back(bus.tx_axis_tdata);
        keep_q.push_back(bus.tx_axis_tkeep);
        cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic queue(input int p, input int n, input int l, input logic [KW-1:0] kl);
    len[p]       = l;
    keep_last[p] = kl;
    pushed[p]    = pushed[p] + n;
  endtask

  task automatic wait_out(input int n, input string tag);
    int c;
    c = 0;
    while (out_q.size() < n && c < 300) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(tag, 64'(out_q.size()), 64'(n));
  endtask

  task automatic check_beat(input string tag, input int idx, input int p, input int b);
    check($sformatf("%s_%0d", tag, idx), out_q[idx], mk(p, b));
  endtask

  task automatic check_cnt(input string tag, input int p, input int exp);
    check($sformatf("%s_p%0d", tag, p), 64'(pkt_cnt[p*32 +: 32]), 64'(exp));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int            base;
  int            c;
  int            r0;
  logic [DW-1:0] held;
  int            exp_p [16];
  int            exp_b [16];

  initial begin
    rst                = 1'b1;
    cnt_clr            = 1'b0;
    port_en            = '1;
    bus.tx_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);
    check("rst_tdata",  bus.tx_axis_tdata,        64'd0);
    check("rst_tkeep",  64'(bus.tx_axis_tkeep),  64'd0);
    check("rst_tlast",  64'(bus.tx_axis_tlast),  64'd0);
    check("rst_rready", 64'(bus.rx_axis_tready), 64'd0);
    check("rst_busy",   64'(busy),               64'd0);
    check("rst_gnt",    64'(gnt_id),             64'd0);
    for (int p = 0; p < N; p++) check_cnt("rst_cnt", p, 0);
    tick();
    rst = 1'b0;
    tick();

    // all four ports, one 3-beat packet each: order 0,1,2,3 with one bubble between packets
    base = out_q.size();
    for (int p = 0; p < N; p++) queue(p, 1, 3, '1);
    wait_out(base + 12, "rr_beats");
    for (int i = 0; i < 12; i++) check_beat("rr_order", base + i, i / 3, i % 3);
    check("rr_span", 64'(cyc_q[base+11] - cyc_q[base]), 64'd14);
    repeat (2) tick();
    for (int p = 0; p < N; p++) check_cnt("rr_cnt", p, 1);
    check("rr_busy_end", 64'(busy), 64'd0);

    // port 2 holds its 5-beat packet while port 1 starts requesting mid-packet
    base = out_q.size();
    queue(2, 1, 5, '1);
    wait_out(base + 2, "lock_early");
    tick();
    queue(1, 1, 2, '1);
    check("lock_gnt2", 64'(gnt_id), 64'd2);
    check("lock_busy", 64'(busy), 64'd1);
    wait_out(base + 7, "lock_beats");
    for (int i = 0; i < 5; i++) check_beat("lock_p2", base + i, 2, i);
    for (int i = 0; i < 2; i++) check_beat("lock_p1", base + 5 + i, 1, i);
    check("lock_span", 64'(cyc_q[base+4] - cyc_q[base]), 64'd4);
    tick();
    check("lock_gnt1", 64'(gnt_id), 64'd1);

    // downstream stall: tready 1,0,0,1 mid-packet
    base = out_q.size();
    queue(0, 1, 4, '1);
    c = 0;
    while (!bus.tx_axis_tvalid && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("stall_first_valid", 64'(bus.tx_axis_tvalid), 64'd1);
    tick();
    bus.tx_axis_tready = 1'b0;
    @(negedge clk);
    #1;
    held = bus.tx_axis_tdata;
    check("stall1_data",  held, mk(0, 1));
    check("stall1_valid", 64'(bus.tx_axis_tvalid), 64'd1);
    tick();
    @(negedge clk);
    #1;
    check("stall2_data",  bus.tx_axis_tdata, held);
    check("stall2_valid", 64'(bus.tx_axis_tvalid), 64'd1);
    tick();
    bus.tx_axis_tready = 1'b1;
    wait_out(base + 4, "stall_beats");
    for (int i = 0; i < 4; i++) check_beat("stall_order", base + i, 0, i);

    // port 2 disabled while everyone requests two 2-beat packets
    port_en = 4'b1011;
    r0      = rdy2_cnt;
    base    = out_q.size();
    for (int p = 0; p < N; p++) queue(p, 2, 2, '1);
    exp_p = '{1, 1, 3, 3, 0, 0, 1, 1, 3, 3, 0, 0, 2, 2, 2, 2};
    exp_b = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    wait_out(base + 12, "en_beats");
    for (int i = 0; i < 12; i++) check_beat("en_order", base + i, exp_p[i], exp_b[i]);
    check("en_rdy2_never", 64'(rdy2_cnt - r0), 64'd0);
    tick();
    port_en = '1;
    wait_out(base + 16, "en_p2_beats");
    for (int i = 12; i < 16; i++) check_beat("en_p2_order", base + i, exp_p[i], exp_b[i]);

    // counters so far, then CntClr colliding with a tlast handshake (tkeep=0 last beat)
    repeat (2) tick();
    check_cnt("acc_cnt", 0, 4);
    check_cnt("acc_cnt", 1, 4);
    check_cnt("acc_cnt", 2, 4);
    check_cnt("acc_cnt", 3, 3);
    queue(0, 1, 1, 8'h00);
    c = 0;
    while (!(bus.tx_axis_tvalid && bus.tx_axis_tready && bus.tx_axis_tlast) && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("clr_found_last", 64'(bus.tx_axis_tvalid && bus.tx_axis_tlast), 64'd1);
    check("clr_keep0",      64'(bus.tx_axis_tkeep), 64'd0);
    check("clr_data",       bus.tx_axis_tdata, mk(0, 0));
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int p = 0; p < N; p++) check_cnt("clr_cnt", p, 0);

    // reset mid-packet, then port 0 and port 3 request together: port 0 first
    base = out_q.size();
    queue(0, 1, 4, '1);
    wait_out(base + 2, "mid_rst_pre");
    check("mid_rst_pre_valid", 64'(bus.tx_axis_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);
    check("mid_rst_tdata",  bus.tx_axis_tdata,        64'd0);
    check("mid_rst_busy",   64'(busy),                64'd0);
    check("mid_rst_rready", 64'(bus.rx_axis_tready),  64'd0);
    check("mid_rst_gnt",    64'(gnt_id),              64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    base = out_q.size();
    queue(3, 1, 2, '1);
    queue(0, 1, 1, '1);
    wait_out(base + 3, "post_rst_beats");
    check_beat("post_rst", base + 0, 0, 0);
    check_beat("post_rst", base + 1, 3, 0);
    check_beat("post_rst", base + 2, 3, 1);
    repeat (2) tick();
    check("post_rst_gnt3", 64'(gnt_id), 64'd3);
    check_cnt("post_rst_cnt", 0, 1);
    check_cnt("post_rst_cnt", 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
